// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, state encoding and select codes for the multi-cycle MIPS control FSM
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_R_EXEC   = 4'd2,
    ST_R_WB     = 4'd3,
    ST_I_EXEC   = 4'd4,
    ST_I_WB     = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_MEM_WB   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS main control FSM with memory handshake timeout
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       branch_ne_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic       ext_op_o,
  output logic       illegal_o,
  output logic       mem_err_o
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_wait;
  logic             timed_out;
  logic             ir_write_dec;
  logic             pc_write_dec;

  // Branch resolution happens in the datapath via pc_write_cond_o; zero_i is not needed here.
  logic unused_zero;
  assign unused_zero = zero_i;

  assign timed_out = (cnt_q == CNT_W'(MEM_TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    mem_wait        = 1'b0;
    pc_write_dec    = 1'b0;
    pc_write_cond_o = 1'b0;
    branch_ne_o     = 1'b0;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_dec    = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SRCB_RT;
    alu_op_o        = ALU_ADD;
    pc_source_o     = PCSRC_ALU;
    ext_op_o        = 1'b1;
    illegal_o       = 1'b0;
    mem_err_o       = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        mem_wait    = 1'b1;
        if (mem_ready_i) begin
          ir_write_dec = 1'b1;
          pc_write_dec = 1'b1;
          state_d      = ST_DECODE;
        end else if (timed_out) begin
          mem_err_o = 1'b1;
        end
      end
      ST_DECODE: begin
        alu_src_b_o = SRCB_IMM_SH;
        case (opcode_i)
          OP_R:                    state_d = ST_R_EXEC;
          OP_LW, OP_SW:            state_d = ST_MEM_ADDR;
          OP_BEQ, OP_BNE:          state_d = ST_BRANCH;
          OP_J:                    state_d = ST_JUMP;
          OP_ADDI, OP_SLTI, OP_ORI: state_d = ST_I_EXEC;
          default: begin
            illegal_o = 1'b1;
            state_d   = ST_FETCH;
          end
        endcase
      end
      ST_R_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
        state_d     = ST_R_WB;
      end
      ST_R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_I_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        ext_op_o    = (opcode_i != OP_ORI);
        if (opcode_i == OP_SLTI)     alu_op_o = ALU_SLT;
        else if (opcode_i == OP_ORI) alu_op_o = ALU_OR;
        state_d = ST_I_WB;
      end
      ST_I_WB: begin
        // Keep the extender mode stable while the result is written back.
        reg_write_o = 1'b1;
        ext_op_o    = (opcode_i != OP_ORI);
        state_d     = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        state_d     = (opcode_i == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        mem_wait   = 1'b1;
        if (mem_ready_i) begin
          state_d = ST_MEM_WB;
        end else if (timed_out) begin
          mem_err_o = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        mem_wait    = 1'b1;
        if (mem_ready_i) begin
          state_d = ST_FETCH;
        end else if (timed_out) begin
          mem_err_o = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALU_SUB;
        pc_source_o     = PCSRC_ALUOUT;
        pc_write_cond_o = 1'b1;
        branch_ne_o     = (opcode_i == OP_BNE);
        state_d         = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write_dec = 1'b1;
        pc_source_o  = PCSRC_JUMP;
        state_d      = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    // Counter restarts on every state entry, including a FETCH that re-enters itself on abort.
    if (!mem_wait || state_d != state_q || mem_err_o) cnt_d = '0;
    else                                               cnt_d = cnt_q + 1'b1;
  end

  // Reset masks the handshake-driven writes so nothing lands while rst_i is low.
  assign ir_write_o = ir_write_dec & rst_i;
  assign pc_write_o = pc_write_dec & rst_i;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam int TMO = 15;

  localparam logic [5:0] R_OP = 6'b000000, J_OP = 6'b000010, BEQ_OP = 6'b000100;
  localparam logic [5:0] BNE_OP = 6'b000101, ADDI_OP = 6'b001000, SLTI_OP = 6'b001010;
  localparam logic [5:0] ORI_OP = 6'b001101, LW_OP = 6'b100011, SW_OP = 6'b101011;

  typedef enum {P_RESET, P_FETCH, P_DECODE, P_REXEC, P_RWB, P_IEXEC, P_IWB,
                P_MADDR, P_MRD, P_MWB, P_MWR, P_BRANCH, P_JUMP} phase_t;

  typedef struct packed {
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       ext_op, illegal, mem_err;
  } ctl_t;

  typedef struct {
    phase_t ph;
    ctl_t   ctl;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic [5:0] opcode_i = '0;
  logic       zero_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       pc_write_o, pc_write_cond_o, branch_ne_o, iord_o, mem_read_o, mem_write_o;
  logic       ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o;
  logic [1:0] alu_src_b_o, pc_source_o;
  logic [2:0] alu_op_o;
  logic       ext_op_o, illegal_o, mem_err_o;
  ctl_t       act;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .branch_ne_o(branch_ne_o),
    .iord_o(iord_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
    .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .pc_source_o(pc_source_o), .ext_op_o(ext_op_o), .illegal_o(illegal_o), .mem_err_o(mem_err_o)
  );

  assign act = {pc_write_o, pc_write_cond_o, branch_ne_o, iord_o, mem_read_o, mem_write_o,
                ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o,
                alu_op_o, pc_source_o, ext_op_o, illegal_o, mem_err_o};

  function automatic bit is_legal(logic [5:0] op);
    return op inside {R_OP, J_OP, BEQ_OP, BNE_OP, ADDI_OP, SLTI_OP, ORI_OP, LW_OP, SW_OP};
  endfunction

  // Expected control word for one cycle of a given instruction phase.
  function automatic ctl_t model(phase_t ph, logic [5:0] op, logic rdy, logic err);
    ctl_t c = '0;
    c.ext_op = 1'b1;
    case (ph)
      P_RESET:  begin c.mem_read = 1; c.alu_src_b = 2'b01; end
      P_FETCH:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy;
                      c.mem_err = err; end
      P_DECODE: begin c.alu_src_b = 2'b11; c.illegal = !is_legal(op); end
      P_REXEC:  begin c.alu_src_a = 1; c.alu_op = 3'b010; end
      P_RWB:    begin c.reg_write = 1; c.reg_dst = 1; end
      P_IEXEC:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.ext_op = (op != ORI_OP);
                      c.alu_op = (op == SLTI_OP) ? 3'b011 : (op == ORI_OP) ? 3'b100 : 3'b000; end
      P_IWB:    begin c.reg_write = 1; c.ext_op = (op != ORI_OP); end
      P_MADDR:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      P_MRD:    begin c.mem_read = 1; c.iord = 1; c.mem_err = err; end
      P_MWB:    begin c.reg_write = 1; c.mem_to_reg = 1; end
      P_MWR:    begin c.mem_write = 1; c.iord = 1; c.mem_err = err; end
      P_BRANCH: begin c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_source = 2'b01;
                      c.pc_write_cond = 1; c.branch_ne = (op == BNE_OP); end
      P_JUMP:   begin c.pc_write = 1; c.pc_source = 2'b10; end
      default:  ;
    endcase
    return c;
  endfunction

  // Drive one cycle of inputs and queue the response expected before the next edge.
  task automatic step(phase_t ph, logic [5:0] op, logic rdy, logic err);
    exp_t e;
    opcode_i    = (ph == P_FETCH || ph == P_RESET) ? 6'($urandom) : op;
    mem_ready_i = rdy;
    zero_i      = 1'($urandom);
    e.ph  = ph;
    e.ctl = model(ph, op, rdy, err);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // Wait phase: ready arrives on cycle w (0-based); beyond the timeout it never arrives.
  task automatic wait_phase(phase_t ph, logic [5:0] op, int w, output bit done);
    done = 0;
    for (int k = 0; k <= TMO; k++) begin
      logic rdy, err;
      rdy = (k == w);
      err = !rdy && (k == TMO);
      step(ph, op, rdy, err);
      if (rdy) begin done = 1; break; end
      if (err) break;
    end
  endtask

  task automatic run_instr(logic [5:0] op, int fwait, int mwait);
    bit done;
    wait_phase(P_FETCH, op, fwait, done);
    if (!done) return;
    step(P_DECODE, op, rbit(), 1'b0);
    case (op)
      R_OP: begin step(P_REXEC, op, rbit(), 0); step(P_RWB, op, rbit(), 0); end
      ADDI_OP, SLTI_OP, ORI_OP: begin step(P_IEXEC, op, rbit(), 0); step(P_IWB, op, rbit(), 0); end
      LW_OP: begin
        step(P_MADDR, op, rbit(), 0);
        wait_phase(P_MRD, op, mwait, done);
        if (done) step(P_MWB, op, rbit(), 0);
      end
      SW_OP: begin
        step(P_MADDR, op, rbit(), 0);
        wait_phase(P_MWR, op, mwait, done);
      end
      BEQ_OP, BNE_OP: step(P_BRANCH, op, rbit(), 0);
      J_OP: step(P_JUMP, op, rbit(), 0);
      default: ;
    endcase
  endtask

  function automatic int rand_wait();
    int r = int'($urandom_range(0, 19));
    if (r == 0) return TMO + 1;
    if (r == 1) return TMO;
    return r % 4;
  endfunction

  function automatic logic [5:0] rand_op();
    logic [5:0] ops [9] = '{R_OP, J_OP, BEQ_OP, BNE_OP, ADDI_OP, SLTI_OP, ORI_OP, LW_OP, SW_OP};
    if ($urandom_range(0, 9) == 0) return 6'($urandom);
    return ops[$urandom_range(0, 8)];
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (act !== e.ctl) begin
          miscompares++;
          $display("FAIL %s: got %h, want %h", e.ph.name(), act, e.ctl);
        end
      end
    end
  end

  initial begin : driver
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(P_RESET, 6'd0, 1'b1, 1'b0);
    rst_i = 1'b1;

    run_instr(R_OP, 0, 0);
    run_instr(ORI_OP, 0, 0);
    run_instr(ADDI_OP, 0, 0);
    run_instr(SLTI_OP, 1, 0);
    run_instr(LW_OP, 0, 3);
    run_instr(BNE_OP, 0, 0);
    run_instr(SW_OP, 0, TMO + 1);
    run_instr(6'b111111, 0, 0);
    run_instr(BEQ_OP, 2, 0);
    run_instr(J_OP, 0, 0);
    run_instr(LW_OP, TMO, TMO);
    run_instr(LW_OP, 0, TMO + 1);
    run_instr(R_OP, TMO + 1, 0);
    run_instr(SW_OP, 0, 0);

    for (int i = 0; i < 200; i++) run_instr(rand_op(), rand_wait(), rand_wait());

    // Asynchronous reset while a store is waiting on memory.
    step(P_FETCH, SW_OP, 1'b1, 1'b0);
    step(P_DECODE, SW_OP, 1'b0, 1'b0);
    step(P_MADDR, SW_OP, 1'b0, 1'b0);
    step(P_MWR, SW_OP, 1'b0, 1'b0);
    begin
      exp_t e;
      opcode_i    = SW_OP;
      mem_ready_i = 1'b1;
      e.ph  = P_RESET;
      e.ctl = model(P_RESET, SW_OP, 1'b1, 1'b0);
      exp_q.push_back(e);
      #1 rst_i = 1'b0;
      #1;
      vectors++;
      if (mem_write_o !== 1'b0 || mem_read_o !== 1'b1) begin
        miscompares++;
        $display("FAIL async_reset: mem_write=%b mem_read=%b, want 0 1", mem_write_o, mem_read_o);
      end
      @(posedge clk);
      #1;
    end
    step(P_RESET, 6'd0, 1'b1, 1'b0);
    rst_i = 1'b1;
    run_instr(R_OP, 0, 0);
    run_instr(LW_OP, 0, 0);

    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
